seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles each digit is lit, minimum 2.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: 1 = scan and display; 0 = all digits off and scan frozen.
REQ-006 Port value, input, 4*NUM_DIGITS: hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-007 Port dp_in, input, NUM_DIGITS: per-digit decimal point request, 1 = lit.
REQ-008 Port blank_lz, input, 1: 1 = suppress leading zeros.
REQ-009 Port load, input, 1: single-cycle strobe that captures value and dp_in into the pending register.
REQ-010 Port seg, output, 7: active-low segments; bit6 = a through bit0 = g.
REQ-011 Port dp, output, 1: active-low decimal point.
REQ-012 Port an, output, NUM_DIGITS: active-low digit enables, one-hot-low.
REQ-013 Port frame_done, output, 1: one-cycle pulse when the digit index wraps to 0.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 while en=1 and wraps to 0; its terminal count is called tick.
REQ-015 On tick, digit index advances by 1 and wraps from NUM_DIGITS-1 to 0; frame_done pulses in the cycle after the wrap tick.
REQ-016 Display is double-buffered: load writes the pending register, and the pending register copies to the active register on the wrap tick only.
REQ-017 If load and the wrap tick coincide, the new value/dp_in go directly to both the pending and active registers.
REQ-018 A load with no wrap tick never changes the digit currently shown.
REQ-019 Segment encoding, active-low, 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-020 Digit i is blank (seg=1111111, dp=1, an bit still low) when blank_lz=1, i>0, and active nibbles i..NUM_DIGITS-1 are all zero; a digit whose dp is set is never blanked.
REQ-021 seg, dp and an are registered and follow the digit index with exactly 1 cycle latency.
REQ-022 When en=0: an = all ones, seg = 1111111, dp = 1, prescaler and index hold, load still updates the pending register.
REQ-023 When en returns to 1, scanning resumes from the held prescaler and index values.
REQ-024 an has exactly one bit low whenever en=1 and reset is not active; no two digits are ever lit together.

Reset
REQ-025 On reset=1 at a clk edge: prescaler=0, index=0, pending=0, active=0, an=all ones, seg=1111111, dp=1, frame_done=0.
REQ-026 Reset asserted mid-frame takes priority over load, tick and en in the same cycle.

Structure
REQ-027 Package seg_pkg holds the 16 segment-code constants, SEG_BLANK=7'b1111111, and the default NUM_DIGITS and REFRESH_DIV.
REQ-028 One combinational sub-module, hex_seg_decode (4-bit in, 7-bit seg out), is instantiated once on the selected nibble.
REQ-029 Index width is $clog2(NUM_DIGITS) and prescaler width is $clog2(REFRESH_DIV); no other arithmetic is required.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset, then load value=16'h12AF, en=1 -> an cycles 1110,1101,1011,0111 every 4 clk after the next frame boundary; seg shows 0111000, 0001000, 0010010, 1001111.
REQ-031 value=16'h0042, blank_lz=1 -> digits 3 and 2 show seg=1111111; digits 1 and 0 show 1001100 and 0010010. Repeat with dp_in=4'b1000 -> digit 3 shows 0000001 with dp=0.
REQ-032 Load 16'h1111 mid-frame, then 16'h2222 in the same cycle as the wrap tick -> 1111 is never displayed; 2222 is displayed from digit 0 of the new frame.
REQ-033 en=0 for 10 cycles mid-digit -> an=1111, prescaler and index hold; after en=1 the frozen digit finishes its remaining cycles.
REQ-034 reset asserted during digit 2 with load=1 -> next cycle an=1111, seg=1111111; load is ignored and active=0.
REQ-035 All tests -> frame_done pulses once per 16 enabled cycles; assertion that $countones(~an) <= 1 holds on every cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: active-low
// glyph codes (bit6 = a .. bit0 = g) and the default geometry.
package seg_pkg;

    localparam int DEFAULT_NUM_DIGITS  = 4;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0001100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_HEX_0;
            4'h1:    code = SEG_HEX_1;
            4'h2:    code = SEG_HEX_2;
            4'h3:    code = SEG_HEX_3;
            4'h4:    code = SEG_HEX_4;
            4'h5:    code = SEG_HEX_5;
            4'h6:    code = SEG_HEX_6;
            4'h7:    code = SEG_HEX_7;
            4'h8:    code = SEG_HEX_8;
            4'h9:    code = SEG_HEX_9;
            4'hA:    code = SEG_HEX_A;
            4'hB:    code = SEG_HEX_B;
            4'hC:    code = SEG_HEX_C;
            4'hD:    code = SEG_HEX_D;
            4'hE:    code = SEG_HEX_E;
            default: code = SEG_HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Signal bundle between a display controller (master) and the scanner
// (slave): value/strobe inputs toward the scanner, panel drive back.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = seg_pkg::DEFAULT_NUM_DIGITS
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;
    logic                      load;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output en, value, dp_in, blank_lz, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  en, value, dp_in, blank_lz, load,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/hex_seg_decode.sv
// Pure combinational hex-nibble to active-low seven-segment glyph.
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with a double-buffered display
// register that only swaps at frame boundaries, so a frame is never torn.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]   act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;

    logic                      tick;
    logic                      wrap_tick;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [3:0]                sel_nib;
    logic                      sel_blank;
    logic                      sel_dp;
    logic [6:0]                dec_seg;

    // A digit is a leading zero when it and everything above it are zero;
    // digit 0 always shows, and a requested decimal point keeps a digit lit.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = blank_lz
                                      && (act_val_q[4*NUM_DIGITS-1:4*gi] == '0)
                                      && !act_dp_q[gi];
            end
        end
    endgenerate

    always_comb begin
        sel_nib   = 4'h0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_nib   = act_val_q[4*i +: 4];
                sel_blank = blank_mask[i];
                sel_dp    = act_dp_q[i];
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (sel_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        tick      = en && (presc_q == LAST_CNT);
        wrap_tick = tick && (idx_q == LAST_IDX);

        presc_d      = presc_q;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        frame_done_d = wrap_tick;
        an_d         = '1;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;

        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
        end
        // A load landing on the wrap tick bypasses the pending stage.
        if (wrap_tick) begin
            act_val_d = load ? value : pend_val_q;
            act_dp_d  = load ? dp_in : pend_dp_q;
        end

        if (en) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = sel_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scenario bench for seg_scan_driver: directed panel checks plus a per-cycle
// reference model that tracks a single enabled-cycle count within the frame.
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (bus.en),
        .value      (bus.value),
        .dp_in      (bus.dp_in),
        .blank_lz   (bus.blank_lz),
        .load       (bus.load),
        .seg        (bus.seg),
        .dp         (bus.dp),
        .an         (bus.an),
        .frame_done (bus.frame_done)
    );

    int compared   = 0;
    int mismatched = 0;
    bit mon_on     = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: m_e = enabled cycles elapsed within the current frame.
    int          m_e;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    logic [3:0]  exp_an;

    always @(negedge clk) begin
        if (mon_on && reset === 1'b0) begin
            compared++;
            if ($countones(~bus.an) > 1) begin
                mismatched++;
                $display("FAIL onehot_an got an=%b required at most one low", bus.an);
            end
        end
    end

    task automatic step();
        int          d;
        logic [15:0] pv_old;
        logic [3:0]  pd_old;
        bit          wrap;
        d = m_e / DIV;
        if (reset) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            exp_fd = bus.en && (m_e == FRAME - 1);
            if (!bus.en) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = ~(4'b0001 << d);
                exp_dp = ~m_ad[d];
                if (bus.blank_lz && d > 0 && (m_av >> (4 * d)) == 16'h0 && !m_ad[d])
                    exp_seg = 7'h7F;
                else
                    exp_seg = seg_tab[m_av[4*d +: 4]];
            end
        end
        @(posedge clk);
        if (reset) begin
            m_e = 0; m_pv = '0; m_pd = '0; m_av = '0; m_ad = '0;
        end else begin
            wrap   = bus.en && (m_e == FRAME - 1);
            pv_old = m_pv;
            pd_old = m_pd;
            if (bus.load) begin
                m_pv = bus.value; m_pd = bus.dp_in;
            end
            if (wrap) begin
                m_av = bus.load ? bus.value : pv_old;
                m_ad = bus.load ? bus.dp_in : pd_old;
            end
            if (bus.en) m_e = (m_e + 1) % FRAME;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.en = 1'b1; bus.load = 1'b0; bus.value = '0;
        bus.dp_in = '0; bus.blank_lz = 1'b0;
        step();
        step();
        compared++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                     bus.an, bus.seg, bus.dp, bus.frame_done);
        end
        reset  = 1'b0;
        mon_on = 1;
        $display("test_reset done");
    endtask

    task automatic test_scan();
        logic [6:0] want [4];
        logic [3:0] an_want;
        bit         found;
        want = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        bus.value = 16'h12AF; bus.dp_in = '0; bus.blank_lz = 1'b0; bus.en = 1'b1; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            compared++;
            if ({bus.seg, bus.dp, bus.an, bus.frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
                mismatched++;
                $display("FAIL scan_model cyc=%0d got seg=%b dp=%b an=%b fd=%b required seg=%b dp=%b an=%b fd=%b",
                         i, bus.seg, bus.dp, bus.an, bus.frame_done, exp_seg, exp_dp, exp_an, exp_fd);
            end
            if (bus.frame_done === 1'b1) found = 1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL scan_frame_done got no pulse in 40 cycles required one");
        end
        for (int k = 0; k < FRAME; k++) begin
            step();
            an_want = ~(4'b0001 << (k / DIV));
            compared++;
            if ({bus.an, bus.seg} !== {an_want, want[k / DIV]}) begin
                mismatched++;
                $display("FAIL scan_12af k=%0d got an=%b seg=%b required an=%b seg=%b",
                         k, bus.an, bus.seg, an_want, want[k / DIV]);
            end
        end
        $display("test_scan value=12af done");
    endtask

    task automatic test_blank_lz();
        logic [6:0] want [4];
        logic       dp_want;
        for (int pass = 0; pass < 2; pass++) begin
            bus.value = 16'h0042; bus.blank_lz = 1'b1; bus.load = 1'b1;
            bus.dp_in = (pass == 0) ? 4'b0000 : 4'b1000;
            want = '{7'b0010010, 7'b1001100, 7'b1111111,
                     (pass == 0) ? 7'b1111111 : 7'b0000001};
            step();
            bus.load = 1'b0;
            for (int i = 0; i < 40 && m_e != 0; i++) step();
            // m_e==0 pre-edge: outputs from the next edge on show digit 0 of the new frame
            for (int k = 0; k < FRAME; k++) begin
                step();
                dp_want = !(pass == 1 && k / DIV == 3);
                compared++;
                if ({bus.seg, bus.dp, bus.an, bus.frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
                    mismatched++;
                    $display("FAIL blank_model pass=%0d k=%0d got seg=%b dp=%b an=%b required seg=%b dp=%b an=%b",
                             pass, k, bus.seg, bus.dp, bus.an, exp_seg, exp_dp, exp_an);
                end
                compared++;
                if ({bus.seg, bus.dp} !== {want[k / DIV], dp_want}) begin
                    mismatched++;
                    $display("FAIL blank_lz pass=%0d k=%0d got seg=%b dp=%b required seg=%b dp=%b",
                             pass, k, bus.seg, bus.dp, want[k / DIV], dp_want);
                end
            end
            $display("test_blank_lz value=0042 dp_in=%b done", bus.dp_in);
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.value = 16'h0000; bus.dp_in = '0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 40 && m_e != 0; i++) step();
        for (int i = 0; i < 40 && m_e != 6; i++) step();
        bus.value = 16'h1111; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 40 && m_e != FRAME - 1; i++) begin
            step();
            compared++;
            if (bus.seg === 7'b1001111) begin
                mismatched++;
                $display("FAIL b2b_no_1111 got seg=%b before wrap required not 1001111", bus.seg);
            end
        end
        bus.value = 16'h2222; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            compared++;
            if ({bus.seg, bus.an} !== {7'b0010010, exp_an} || bus.an !== ~(4'b0001 << (k / DIV))) begin
                mismatched++;
                $display("FAIL b2b_2222 k=%0d got seg=%b an=%b required seg=0010010 an=%b",
                         k, bus.seg, bus.an, exp_an);
            end
        end
        $display("test_back_to_back load 1111 then 2222 on wrap done");
    endtask

    task automatic test_freeze();
        logic [3:0] an_want;
        for (int i = 0; i < 40 && m_e != 5; i++) step();
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            compared++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
                mismatched++;
                $display("FAIL freeze_off i=%0d got an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1",
                         i, bus.an, bus.seg, bus.dp);
            end
        end
        bus.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            an_want = (k < 3) ? 4'b1101 : 4'b1011;
            compared++;
            if (bus.an !== an_want) begin
                mismatched++;
                $display("FAIL freeze_resume k=%0d got an=%b required an=%b", k, bus.an, an_want);
            end
        end
        $display("test_freeze en low 10 cycles done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 40 && m_e != 2 * DIV + 1; i++) step();
        reset = 1'b1; bus.load = 1'b1; bus.value = 16'hABCD; bus.dp_in = 4'hF;
        step();
        compared++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid got an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        reset = 1'b0; bus.load = 1'b0;
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            step();
            compared++;
            if ({bus.seg, bus.dp, bus.an, bus.frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}
                || bus.seg !== 7'b0000001) begin
                mismatched++;
                $display("FAIL reset_mid_after k=%0d got seg=%b dp=%b an=%b fd=%b required seg=0000001 dp=%b an=%b fd=%b",
                         k, bus.seg, bus.dp, bus.an, bus.frame_done, exp_dp, exp_an, exp_fd);
            end
        end
        $display("test_reset_mid load ignored done");
    endtask

    task automatic test_random();
        int loads = 0;
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            bus.en       = ($urandom_range(0, 7) != 0);
            bus.load     = ($urandom_range(0, 5) == 0);
            bus.value    = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bus.value[15:8] = 8'h00;
            bus.dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.blank_lz = 1'($urandom);
            if (bus.load) loads++;
            step();
            compared++;
            if ({bus.seg, bus.dp, bus.an, bus.frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
                mismatched++;
                $display("FAIL random cyc=%0d got seg=%b dp=%b an=%b fd=%b required seg=%b dp=%b an=%b fd=%b",
                         i, bus.seg, bus.dp, bus.an, bus.frame_done, exp_seg, exp_dp, exp_an, exp_fd);
            end
        end
        reset = 1'b0; bus.load = 1'b0; bus.en = 1'b1;
        $display("test_random 600 cycles, %0d loads done", loads);
    endtask

    initial begin
        m_e = 0; m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0;
        test_reset();
        test_scan();
        test_blank_lz();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        test_random();
        mon_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
